// File: rtl/regfile_multiport_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_pkg : shared constants, types and helpers for regfile_multiport  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package regfile_pkg;

  localparam int c_DEF_DATA_WIDTH = 64;
  localparam int c_DEF_NUM_REGS   = 32;
  localparam int c_DEF_NUM_READ   = 2;
  localparam int c_DEF_NUM_WRITE  = 1;
  localparam int c_DEF_BYPASS     = 1;
  localparam int c_DEF_ZERO_REG   = 1;

  // A 1-wide address still needs one bit, hence the floor at 1.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int c_DEF_ADDR_W = addr_w(c_DEF_NUM_REGS);

  typedef logic [c_DEF_ADDR_W-1:0]     reg_addr_t;
  typedef logic [c_DEF_DATA_WIDTH-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_multiport_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_multiport_if : read/write/issue bus of the multi-port regfile    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface regfile_multiport_if #(
  parameter int DATA_WIDTH = regfile_pkg::c_DEF_DATA_WIDTH,
  parameter int NUM_REGS   = regfile_pkg::c_DEF_NUM_REGS,
  parameter int NUM_READ   = regfile_pkg::c_DEF_NUM_READ,
  parameter int NUM_WRITE  = regfile_pkg::c_DEF_NUM_WRITE
);
  localparam int ADDR_W = regfile_pkg::addr_w(NUM_REGS);

  logic [NUM_WRITE-1:0]            we;
  logic [NUM_WRITE*ADDR_W-1:0]     waddr;
  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata;
  logic [NUM_READ*ADDR_W-1:0]      raddr;
  logic [NUM_READ*DATA_WIDTH-1:0]  rdata;
  logic [NUM_READ-1:0]             rbusy;
  logic                            issue_valid;
  logic [ADDR_W-1:0]               issue_rd;
  logic [NUM_REGS-1:0]             busy_vec;

  modport master (
    output we, waddr, wdata, raddr, issue_valid, issue_rd,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue_valid, issue_rd,
    output rdata, rbusy, busy_vec
  );
endinterface
`default_nettype wire

// File: rtl/regfile_multiport_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_scoreboard : per-register busy FSMs and per-read busy lookup     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  parameter int ADDR_W    = 5
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic [NUM_WRITE-1:0]        i_we,
  input  wire logic [NUM_WRITE*ADDR_W-1:0] i_waddr,
  input  wire logic                        i_issue_valid,
  input  wire logic [ADDR_W-1:0]           i_issue_rd,
  input  wire logic [NUM_READ*ADDR_W-1:0]  i_raddr,
  output logic      [NUM_REGS-1:0]         o_busy_vec,
  output logic      [NUM_READ-1:0]         o_rbusy
);
  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;

  logic [NUM_REGS-1:0] r_state;
  logic [NUM_REGS-1:0] w_state_nxt;
  logic [NUM_REGS-1:0] w_wr_hit;
  logic [NUM_REGS-1:0] w_iss_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_state[r] <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_wr_hit  = '0;
    w_iss_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (i_we[j] && (i_waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) w_wr_hit[r] = 1'b1;
      end
      w_iss_hit[r] = i_issue_valid && (i_issue_rd == ADDR_W'(r))
                     && !((ZERO_REG != 0) && (r == 0));
    end
  end

  // A new issue beats a same-cycle writeback: the fresh producer still owes a result.
  always_comb begin
    w_state_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      case (r_state[r])
        c_IDLE:  w_state_nxt[r] = w_iss_hit[r] ? c_BUSY : c_IDLE;
        c_BUSY:  w_state_nxt[r] = (w_iss_hit[r] || !w_wr_hit[r]) ? c_BUSY : c_IDLE;
        default: w_state_nxt[r] = c_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) o_busy_vec[r] = (r_state[r] == c_BUSY);
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rbusy
    logic [ADDR_W-1:0] w_ra;
    logic              w_rbusy;

    assign w_ra = i_raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_rbusy = o_busy_vec[w_ra];
      if ((BYPASS != 0) && w_wr_hit[w_ra]) w_rbusy = 1'b0;
      if ((ZERO_REG != 0) && (w_ra == '0)) w_rbusy = 1'b0;
    end

    assign o_rbusy[i] = w_rbusy;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_multiport : multi-port register file with bypass and scoreboard  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int NUM_REGS   = c_DEF_NUM_REGS,
  parameter int NUM_READ   = c_DEF_NUM_READ,
  parameter int NUM_WRITE  = c_DEF_NUM_WRITE,
  parameter int BYPASS     = c_DEF_BYPASS,
  parameter int ZERO_REG   = c_DEF_ZERO_REG
) (
  input  wire logic          clk,
  input  wire logic          rst,
  regfile_multiport_if.slave bus
);
  localparam int ADDR_W = addr_w(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  // Later ports overwrite earlier ones in the same edge, so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_mem[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (bus.we[j] && !((ZERO_REG != 0) && (bus.waddr[j*ADDR_W +: ADDR_W] == '0))) begin
          r_mem[bus.waddr[j*ADDR_W +: ADDR_W]] <= bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDR_W-1:0]     w_ra;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_ra = bus.raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_rdata = r_mem[w_ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (bus.we[j] && (bus.waddr[j*ADDR_W +: ADDR_W] == w_ra)) begin
            w_rdata = bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      if ((ZERO_REG != 0) && (w_ra == '0)) w_rdata = '0;
    end

    assign bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
  end

  regfile_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .BYPASS    (BYPASS),
    .ZERO_REG  (ZERO_REG),
    .ADDR_W    (ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_we          (bus.we),
    .i_waddr       (bus.waddr),
    .i_issue_valid (bus.issue_valid),
    .i_issue_rd    (bus.issue_rd),
    .i_raddr       (bus.raddr),
    .o_busy_vec    (bus.busy_vec),
    .o_rbusy       (bus.rbusy)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_multiport : directed checks on a bypassing 2-write instance   |
// | and a non-bypassing 1-write instance.  Rev 1.0                           |
// +--------------------------------------------------------------------------+
module tb_regfile_multiport;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_WIDTH(64), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2)) ia ();
  regfile_multiport_if #(.DATA_WIDTH(64), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(1)) ib ();

  regfile_multiport #(
    .DATA_WIDTH(64), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1), .ZERO_REG(1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  regfile_multiport #(
    .DATA_WIDTH(64), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(1), .BYPASS(0), .ZERO_REG(1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic exp_push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q_exp.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (q_exp.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = q_exp.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    ia.we = '0; ia.waddr = '0; ia.wdata = '0; ia.raddr = '0;
    ia.issue_valid = 1'b0; ia.issue_rd = '0;
    ib.we = '0; ib.waddr = '0; ib.wdata = '0; ib.raddr = '0;
    ib.issue_valid = 1'b0; ib.issue_rd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Post-reset state
    ia.raddr[4:0] = 5'd5; ib.raddr[4:0] = 5'd5;
    exp_push("rst_rdata_a", 64'h0);
    exp_push("rst_busy_a", 64'h0);
    exp_push("rst_rbusy_a", 64'h0);
    exp_push("rst_rdata_b", 64'h0);
    settle();
    chk(ia.rdata[63:0]);
    chk(64'(ia.busy_vec));
    chk(64'(ia.rbusy));
    chk(ib.rdata[63:0]);

    // Preload r5, reserve r7, then reset with a write and issue that must be dropped
    idle();
    ia.we[0] = 1'b1; ia.waddr[4:0] = 5'd5; ia.wdata[63:0] = 64'hDEAD;
    ia.issue_valid = 1'b1; ia.issue_rd = 5'd7;
    ib.we[0] = 1'b1; ib.waddr[4:0] = 5'd5; ib.wdata[63:0] = 64'hDEAD;
    ib.issue_valid = 1'b1; ib.issue_rd = 5'd7;
    tick();
    idle();
    ia.raddr[4:0] = 5'd5; ia.raddr[9:5] = 5'd7;
    exp_push("pre_rdata_a", 64'hDEAD);
    exp_push("pre_rbusy_a", 64'h2);
    exp_push("pre_busy_a", 64'h80);
    settle();
    chk(ia.rdata[63:0]);
    chk(64'(ia.rbusy));
    chk(64'(ia.busy_vec));
    rst = 1'b1;
    ia.we[0] = 1'b1; ia.waddr[4:0] = 5'd5; ia.wdata[63:0] = 64'hBEEF;
    ia.issue_valid = 1'b1; ia.issue_rd = 5'd9;
    tick();
    rst = 1'b0;
    idle();
    ia.raddr[4:0] = 5'd5; ib.raddr[4:0] = 5'd5;
    exp_push("midrst_rdata_a", 64'h0);
    exp_push("midrst_busy_a", 64'h0);
    exp_push("midrst_rdata_b", 64'h0);
    exp_push("midrst_busy_b", 64'h0);
    settle();
    chk(ia.rdata[63:0]);
    chk(64'(ia.busy_vec));
    chk(ib.rdata[63:0]);
    chk(64'(ib.busy_vec));

    // Same-cycle bypass vs stored-value read
    idle();
    ia.we[0] = 1'b1; ia.waddr[4:0] = 5'd3; ia.wdata[63:0] = 64'h1234; ia.raddr[4:0] = 5'd3;
    ib.we[0] = 1'b1; ib.waddr[4:0] = 5'd3; ib.wdata[63:0] = 64'h1234; ib.raddr[4:0] = 5'd3;
    exp_push("byp_same_a", 64'h1234);
    exp_push("nobyp_same_b", 64'h0);
    settle();
    chk(ia.rdata[63:0]);
    chk(ib.rdata[63:0]);
    tick();
    idle();
    ia.raddr[4:0] = 5'd3; ib.raddr[4:0] = 5'd3;
    exp_push("byp_next_a", 64'h1234);
    exp_push("nobyp_next_b", 64'h1234);
    exp_push("idle_write_busy_a", 64'h0);
    settle();
    chk(ia.rdata[63:0]);
    chk(ib.rdata[63:0]);
    chk(64'(ia.busy_vec));

    // Register 0 is hardwired
    idle();
    ia.we[0] = 1'b1; ia.waddr[4:0] = 5'd0; ia.wdata[63:0] = 64'hFFFF;
    ia.issue_valid = 1'b1; ia.issue_rd = 5'd0;
    exp_push("zero_same_a", 64'h0);
    settle();
    chk(ia.rdata[63:0]);
    tick();
    idle();
    exp_push("zero_next_a", 64'h0);
    exp_push("zero_busy_a", 64'h0);
    exp_push("zero_rbusy_a", 64'h0);
    settle();
    chk(ia.rdata[63:0]);
    chk(64'(ia.busy_vec));
    chk(64'(ia.rbusy));

    // Two write ports on the same register: port 1 wins
    idle();
    ia.we = 2'b11;
    ia.waddr[4:0] = 5'd9; ia.wdata[63:0]   = 64'hA;
    ia.waddr[9:5] = 5'd9; ia.wdata[127:64] = 64'hB;
    ia.raddr[9:5] = 5'd9;
    exp_push("conflict_byp_a", 64'hB);
    settle();
    chk(ia.rdata[127:64]);
    tick();
    idle();
    ia.raddr[9:5] = 5'd9;
    exp_push("conflict_store_a", 64'hB);
    settle();
    chk(ia.rdata[127:64]);

    // Two write ports on distinct registers
    idle();
    ia.we = 2'b11;
    ia.waddr[4:0] = 5'd10; ia.wdata[63:0]   = 64'h10;
    ia.waddr[9:5] = 5'd11; ia.wdata[127:64] = 64'h11;
    tick();
    idle();
    ia.raddr[4:0] = 5'd10; ia.raddr[9:5] = 5'd11;
    exp_push("dual_r10_a", 64'h10);
    exp_push("dual_r11_a", 64'h11);
    settle();
    chk(ia.rdata[63:0]);
    chk(ia.rdata[127:64]);

    // Reserve r4, then write it back
    idle();
    ia.issue_valid = 1'b1; ia.issue_rd = 5'd4; ia.raddr[4:0] = 5'd4;
    ib.issue_valid = 1'b1; ib.issue_rd = 5'd4; ib.raddr[4:0] = 5'd4;
    exp_push("issue_same_rbusy_a", 64'h0);
    settle();
    chk(64'(ia.rbusy[0]));
    tick();
    idle();
    ia.raddr[4:0] = 5'd4; ib.raddr[4:0] = 5'd4;
    exp_push("issue_rbusy_a", 64'h1);
    exp_push("issue_rbusy_b", 64'h1);
    exp_push("issue_busy_a", 64'h10);
    settle();
    chk(64'(ia.rbusy[0]));
    chk(64'(ib.rbusy[0]));
    chk(64'(ia.busy_vec));
    ia.we[0] = 1'b1; ia.waddr[4:0] = 5'd4; ia.wdata[63:0] = 64'h55;
    ib.we[0] = 1'b1; ib.waddr[4:0] = 5'd4; ib.wdata[63:0] = 64'h55;
    exp_push("wb_rbusy_a", 64'h0);
    exp_push("wb_rdata_a", 64'h55);
    exp_push("wb_rbusy_b", 64'h1);
    exp_push("wb_rdata_b", 64'h0);
    settle();
    chk(64'(ia.rbusy[0]));
    chk(ia.rdata[63:0]);
    chk(64'(ib.rbusy[0]));
    chk(ib.rdata[63:0]);
    tick();
    idle();
    ib.raddr[4:0] = 5'd4;
    exp_push("wb_busy_a", 64'h0);
    exp_push("wb_busy_b", 64'h0);
    exp_push("wb_rdata_next_b", 64'h55);
    settle();
    chk(64'(ia.busy_vec));
    chk(64'(ib.busy_vec));
    chk(ib.rdata[63:0]);

    // Issue and writeback of the same busy register in one cycle
    idle();
    ia.issue_valid = 1'b1; ia.issue_rd = 5'd6;
    tick();
    idle();
    ia.issue_valid = 1'b1; ia.issue_rd = 5'd6;
    ia.we[0] = 1'b1; ia.waddr[4:0] = 5'd6; ia.wdata[63:0] = 64'h77;
    tick();
    idle();
    ia.raddr[4:0] = 5'd6;
    exp_push("collide_rdata_a", 64'h77);
    exp_push("collide_busy_a", 64'h40);
    exp_push("collide_rbusy_a", 64'h1);
    settle();
    chk(ia.rdata[63:0]);
    chk(64'(ia.busy_vec));
    chk(64'(ia.rbusy[0]));

    // Re-issue of a busy register keeps it busy; a plain write then frees it
    ia.issue_valid = 1'b1; ia.issue_rd = 5'd6;
    tick();
    idle();
    exp_push("reissue_busy_a", 64'h40);
    settle();
    chk(64'(ia.busy_vec));
    ia.we[0] = 1'b1; ia.waddr[4:0] = 5'd6; ia.wdata[63:0] = 64'h88;
    tick();
    idle();
    ia.raddr[4:0] = 5'd6;
    exp_push("free_busy_a", 64'h0);
    exp_push("free_rdata_a", 64'h88);
    settle();
    chk(64'(ia.busy_vec));
    chk(ia.rdata[63:0]);

    if (q_exp.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", q_exp.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
